// File: rtl/arm_fetch_pkg.sv
// Shared types for the fetch stage: widths, fetch state encoding and the
// prefetch queue entry layout.
package arm_fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC step; wraps modulo 2^64 by construction.
    function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
        return pc + PC_W'(4);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instr} entries. Flush empties the queue
// and takes priority over any push or pop in the same cycle.
module fetch_queue
    import arm_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
    assert property (@(posedge clk) disable iff (reset) (wr_ptr - rd_ptr) == count[PW-1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction memory request, prefetch queue and
// redirect handling. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  RUN   | fetching sequentially, honouring redirects and decode backpressure
//  FAULT | misaligned redirect seen; fetch halted, queue empty until reset
module instr_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0,
    parameter int DEPTH    = 4,
    parameter int IM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    IM_Address,
    input  logic [INSTR_W-1:0] IM_Instruction,
    input  logic               Redirect,
    input  logic [PC_W-1:0]    RedirectPC,
    output logic               Out_Valid,
    input  logic               Out_Ready,
    output logic [INSTR_W-1:0] Out_Instruction,
    output logic [PC_W-1:0]    Out_PC,
    output logic               Fault
);

    localparam int AW = $clog2(IM_WORDS);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] redirect_target;
    logic            misaligned;
    logic            q_push;
    logic            q_pop;
    logic            q_flush;
    logic            q_full;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_wdata;
    fetch_entry_t    q_head;
    logic            unused_count;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (RedirectPC[1:0] != 2'b00);
    assign Fault      = (state == FAULT);
`else
    logic unused_redirect_lsbs;
    assign misaligned           = 1'b0;
    assign Fault                = 1'b0;
    assign unused_redirect_lsbs = ^RedirectPC[1:0];
`endif

    assign unused_count    = ^q_count;
    assign redirect_target = {RedirectPC[PC_W-1:2], 2'b00};

    assign IM_Address      = {{(PC_W-AW){1'b0}}, pc[2 +: AW]};
    assign Out_Valid       = (state == RUN) && !q_empty;
    assign q_pop           = Out_Valid && Out_Ready;
    assign q_wdata         = '{pc: pc, instr: IM_Instruction};
    assign Out_PC          = q_head.pc;
    assign Out_Instruction = q_head.instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= {RESET_PC[PC_W-1:2], 2'b00};
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        q_push     = 1'b0;
        q_flush    = 1'b0;
        case (state)
            RUN: begin
                if (Redirect) begin
                    // Any head consumed in this cycle is discarded with the flush.
                    q_flush = 1'b1;
                    if (misaligned) begin
                        state_next = FAULT;
                    end else begin
                        pc_next = redirect_target;
                    end
                end else if (!q_full || q_pop) begin
                    q_push  = 1'b1;
                    pc_next = pc_incr(pc);
                end
            end
            FAULT: begin
                q_flush = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .wdata (q_wdata),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (q_head)
    );

    assert property (@(posedge clk) disable iff (reset) pc[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations followed by randomized traffic checked against a queue model.
module tb_instr_fetch_unit;
    import arm_fetch_pkg::*;

    localparam int DEPTH    = 4;
    localparam int IM_WORDS = 1024;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] IM_Address;
    logic [31:0] IM_Instruction;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instruction;
    logic [63:0] Out_PC;
    logic        Fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: word i holds the value i.
    function automatic logic [31:0] mem_word(input logic [63:0] idx);
        return idx[31:0];
    endfunction

    assign IM_Instruction = mem_word(IM_Address);

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .IM_WORDS (IM_WORDS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IM_Address      (IM_Address),
        .IM_Instruction  (IM_Instruction),
        .Redirect        (Redirect),
        .RedirectPC      (RedirectPC),
        .Out_Valid       (Out_Valid),
        .Out_Ready       (Out_Ready),
        .Out_Instruction (Out_Instruction),
        .Out_PC          (Out_PC),
        .Fault           (Fault)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: PC plus an ordered list of pending {pc, instr} entries.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    bit          m_fault = 0;
    bit          m_live  = 0;
    bit          m_pop;

    function automatic logic [63:0] word_index(input logic [63:0] p);
        return (p >> 2) % IM_WORDS;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc    = RESET_PC;
            m_q.delete();
            m_fault = 0;
            m_live  = 1;
        end else if (m_live && !m_fault) begin
            m_pop = (m_q.size() > 0) && Out_Ready;
            if (Redirect) begin
                m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                if (RedirectPC % 4 != 0) m_fault = 1;
                else m_pc = RedirectPC;
`else
                m_pc = RedirectPC - (RedirectPC % 4);
`endif
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_q.size() < DEPTH) begin
                    m_q.push_back('{pc: m_pc, instr: mem_word(word_index(m_pc))});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    logic exp_valid;
    always @(negedge clk) begin
        if (m_live) begin
            exp_valid = (m_q.size() > 0) && !m_fault;
            chk("out_valid", Out_Valid, exp_valid);
            if (exp_valid) begin
                chk("out_pc", Out_PC, m_q[0].pc);
                chk("out_instr", Out_Instruction, m_q[0].instr);
            end
            chk("im_address", IM_Address, word_index(m_pc));
            chk("fault", Fault, m_fault);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart(input logic ready);
        reset     = 1'b1;
        Out_Ready = ready;
        Redirect  = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 64'h0;
        Out_Ready  = 1'b1;
        step(3);
        chk("rst_valid", Out_Valid, 1'b0);
        chk("rst_pc", Out_PC, 64'h0);
        chk("rst_instr", Out_Instruction, 32'h0);
        chk("rst_fault", Fault, 1'b0);
        chk("rst_imaddr", IM_Address, 64'h0);

        // Streaming after reset release.
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("stream_valid", Out_Valid, 1'b1);
            chk("stream_pc", Out_PC, 64'(4 * k));
            chk("stream_instr", Out_Instruction, 32'(k));
        end

        // Backpressure: queue fills, PC stops, then drains without gaps.
        restart(1'b0);
        step(10);
        chk("stall_pc", Out_PC, 64'h0);
        chk("stall_imaddr", IM_Address, 64'd4);
        Out_Ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk("drain_valid", Out_Valid, 1'b1);
            chk("drain_pc", Out_PC, 64'(4 * k));
            chk("drain_instr", Out_Instruction, 32'(k));
        end

        // Redirect with three entries queued.
        restart(1'b0);
        step(3);
        Redirect   = 1'b1;
        RedirectPC = 64'h100;
        step(1);
        chk("redir_bubble", Out_Valid, 1'b0);
        Redirect  = 1'b0;
        Out_Ready = 1'b1;
        step(1);
        chk("redir_valid", Out_Valid, 1'b1);
        chk("redir_pc", Out_PC, 64'h100);
        chk("redir_instr", Out_Instruction, 32'd64);

        // Reset wins over a simultaneous redirect.
        Redirect   = 1'b1;
        RedirectPC = 64'h500;
        reset      = 1'b1;
        step(1);
        chk("rstredir_valid", Out_Valid, 1'b0);
        chk("rstredir_imaddr", IM_Address, 64'h0);
        Redirect = 1'b0;
        reset    = 1'b0;
        step(1);
        chk("rstredir_pc", Out_PC, 64'h0);

        // Word index wraps at IM_WORDS.
        Redirect   = 1'b1;
        RedirectPC = 64'hFF8;
        step(1);
        Redirect = 1'b0;
        chk("wrap_imaddr0", IM_Address, 64'd1022);
        step(1);
        chk("wrap_imaddr1", IM_Address, 64'd1023);
        step(1);
        chk("wrap_imaddr2", IM_Address, 64'd0);
        chk("wrap_pc", Out_PC, 64'hFFC);
        chk("wrap_instr", Out_Instruction, 32'd1023);
        step(1);
        chk("wrap_pc2", Out_PC, 64'h1000);
        chk("wrap_instr2", Out_Instruction, 32'd0);

        // PC wraps modulo 2^64.
        Redirect   = 1'b1;
        RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
        step(1);
        Redirect = 1'b0;
        chk("pcwrap_imaddr", IM_Address, 64'd1023);
        step(1);
        chk("pcwrap_pc0", Out_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("pcwrap_imaddr1", IM_Address, 64'd0);
        step(1);
        chk("pcwrap_pc1", Out_PC, 64'h0);

        // Misaligned redirect.
        Redirect   = 1'b1;
        RedirectPC = 64'h102;
        step(1);
        Redirect = 1'b0;
        chk("mis_bubble", Out_Valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", Fault, 1'b1);
        step(1);
        chk("mis_hold_valid", Out_Valid, 1'b0);
        Redirect   = 1'b1;
        RedirectPC = 64'h200;
        step(1);
        Redirect = 1'b0;
        step(1);
        chk("mis_ignored_valid", Out_Valid, 1'b0);
        chk("mis_sticky", Fault, 1'b1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mis_cleared", Fault, 1'b0);
`else
        chk("mis_nofault", Fault, 1'b0);
        chk("mis_imaddr", IM_Address, 64'h40);
        step(1);
        chk("mis_valid", Out_Valid, 1'b1);
        chk("mis_pc", Out_PC, 64'h100);
        chk("mis_instr", Out_Instruction, 32'd64);
`endif

        // Randomized traffic; ready probability varies per block.
        for (int blk = 0; blk < 15; blk++) begin
            int ready_pct;
            ready_pct = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                step(1);
                reset     = ($urandom_range(0, 99) == 0);
                Out_Ready = ($urandom_range(1, 100) <= ready_pct);
                Redirect  = ($urandom_range(0, 99) < 5);
                case ($urandom_range(0, 3))
                    0: RedirectPC = 64'($urandom_range(0, 4095)) << 2;
                    1: RedirectPC = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                    2: RedirectPC = {$urandom, $urandom};
                    default: RedirectPC = 64'h0FF0 + (64'($urandom_range(0, 7)) << 2);
                endcase
            end
        end
        reset    = 1'b0;
        Redirect = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
